// File: rtl/vram_px_fill.sv
// Rectangle fill engine: writes one clipped, solid-colour pixel per clock into the vramPX write port.
// Optional macro VRAM_PX_FILL_VSYNC_EN holds each non-empty fill until the next frame_drawn pulse.
module vram_px_fill #(
  parameter int H_RES     = 320,
  parameter int V_RES     = 240,
  parameter int ADDR_BITS = 17
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [8:0]           cmd_x,
  input  logic [7:0]           cmd_y,
  input  logic [8:0]           cmd_w,
  input  logic [7:0]           cmd_h,
  input  logic [7:0]           cmd_color,
  input  logic                 frame_drawn,
  output logic [ADDR_BITS-1:0] vram_addr,
  output logic [7:0]           vram_d,
  output logic                 vram_we,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, SYNC, FILL, DONE} state_t;

  state_t               state, state_nxt;
  logic [8:0]           col, col_nxt, ew, ew_nxt;
  logic [7:0]           row, row_nxt, eh, eh_nxt;
  logic [ADDR_BITS-1:0] row_base, row_base_nxt;
  logic [7:0]           color, color_nxt;
  logic [ADDR_BITS-1:0] addr_nxt;
  logic [7:0]           d_nxt;
  logic                 we_nxt;

  logic [9:0]           room_x;
  logic [8:0]           room_y;
  logic [8:0]           clip_w;
  logic [7:0]           clip_h;
  logic                 cmd_empty;
  logic [ADDR_BITS-1:0] start_addr;
  logic                 row_end, last_px;

  // Clip against the right/bottom edges; room_* are only meaningful for on-screen origins.
  assign room_x     = 10'(H_RES) - {1'b0, cmd_x};
  assign room_y     = 9'(V_RES) - {1'b0, cmd_y};
  assign clip_w     = ({1'b0, cmd_w} < room_x) ? cmd_w : room_x[8:0];
  assign clip_h     = ({1'b0, cmd_h} < room_y) ? cmd_h : room_y[7:0];
  assign cmd_empty  = (cmd_x >= 9'(H_RES)) || (cmd_y >= 8'(V_RES)) ||
                      (cmd_w == 9'd0) || (cmd_h == 8'd0);
  assign start_addr = ADDR_BITS'(cmd_y) * ADDR_BITS'(H_RES) + ADDR_BITS'(cmd_x);

  assign row_end = (col == ew - 9'd1);
  assign last_px = row_end && (row == eh - 8'd1);

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

`ifndef VRAM_PX_FILL_VSYNC_EN
  logic unused_frame_drawn;
  assign unused_frame_drawn = frame_drawn;
`endif

  always_comb begin
    state_nxt    = state;
    col_nxt      = col;
    row_nxt      = row;
    ew_nxt       = ew;
    eh_nxt       = eh;
    row_base_nxt = row_base;
    color_nxt    = color;
    we_nxt       = 1'b0;
    addr_nxt     = vram_addr;
    d_nxt        = vram_d;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          ew_nxt       = clip_w;
          eh_nxt       = clip_h;
          color_nxt    = cmd_color;
          row_base_nxt = start_addr;
          col_nxt      = 9'd0;
          row_nxt      = 8'd0;
          if (cmd_empty) begin
            state_nxt = DONE;
          end else begin
`ifdef VRAM_PX_FILL_VSYNC_EN
            state_nxt = SYNC;
`else
            state_nxt = FILL;
            we_nxt    = 1'b1;
            addr_nxt  = start_addr;
            d_nxt     = cmd_color;
`endif
          end
        end
      end
`ifdef VRAM_PX_FILL_VSYNC_EN
      SYNC: begin
        if (frame_drawn) begin
          state_nxt = FILL;
          we_nxt    = 1'b1;
          addr_nxt  = row_base;
          d_nxt     = color;
        end
      end
`endif
      FILL: begin
        // vram_addr already holds the pixel being written this cycle; compute the next one.
        if (last_px) begin
          state_nxt = DONE;
        end else begin
          we_nxt = 1'b1;
          d_nxt  = color;
          if (row_end) begin
            col_nxt      = 9'd0;
            row_nxt      = row + 8'd1;
            row_base_nxt = row_base + ADDR_BITS'(H_RES);
            addr_nxt     = row_base + ADDR_BITS'(H_RES);
          end else begin
            col_nxt  = col + 9'd1;
            addr_nxt = vram_addr + ADDR_BITS'(1);
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state     <= IDLE;
      vram_we   <= 1'b0;
      vram_addr <= '0;
      vram_d    <= '0;
    end else begin
      state     <= state_nxt;
      vram_we   <= we_nxt;
      vram_addr <= addr_nxt;
      vram_d    <= d_nxt;
    end
  end

  // Command-shadow registers are always rewritten at accept, so they need no reset.
  always_ff @(posedge clk) begin
    col      <= col_nxt;
    row      <= row_nxt;
    ew       <= ew_nxt;
    eh       <= eh_nxt;
    row_base <= row_base_nxt;
    color    <= color_nxt;
  end

endmodule
